// File: rtl/seq_div_signed16by8.sv
// Signed 2W/W restoring divider, one quotient bit per cycle; DIV_SAT_EN saturates the -2^(2W-1)/-1 quotient.
// Latency: 2W+2 cycles from accept to out_valid (2 for divide-by-zero); one operation in flight at a time.
// Backpressure: result held with out_valid until out_ready; in_ready low from accept until after that handshake.
module seq_div_signed16by8 #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] quotient,
   output logic [W-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);
   localparam int DW = 2*W;
   localparam int CW = $clog2(DW);
   localparam logic [DW-1:0] QMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] QMIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t        state;
   // Unsigned magnitude: the dividend shifts out MSB-first while quotient bits shift in at the bottom.
   logic [DW-1:0] dq;
   logic [W-1:0]  dvs_mag;
   logic [W:0]    prem;
   logic [CW-1:0] cnt;
   logic          dvd_neg;
   logic          dvs_neg;
   logic          dvs_zero;
   logic          ovf_case;

   logic [W+1:0]  shifted;
   logic [W+1:0]  trial;
   logic          qbit;

   always_comb begin
      shifted = {prem, dq[DW-1]};
      trial   = shifted - {2'b00, dvs_mag};
      qbit    = ~trial[W+1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         dq          <= '0;
         dvs_mag     <= '0;
         prem        <= '0;
         cnt         <= '0;
         dvd_neg     <= 1'b0;
         dvs_neg     <= 1'b0;
         dvs_zero    <= 1'b0;
         ovf_case    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  dq       <= dividend[DW-1] ? -dividend : dividend;
                  dvs_mag  <= divisor[W-1] ? -divisor : divisor;
                  prem     <= '0;
                  cnt      <= CW'(DW-1);
                  dvd_neg  <= dividend[DW-1];
                  dvs_neg  <= divisor[W-1];
                  dvs_zero <= (divisor == '0);
                  ovf_case <= (dividend == QMIN) && (divisor == '1);
                  state    <= (divisor == '0) ? FIX : CALC;
               end
            end
            CALC: begin
               dq   <= {dq[DW-2:0], qbit};
               prem <= qbit ? trial[W:0] : {prem[W-1:0], dq[DW-1]};
               if (cnt == '0)
                  state <= FIX;
               else
                  cnt <= cnt - CW'(1);
            end
            FIX: begin
               if (dvs_zero) begin
                  quotient    <= dvd_neg ? QMIN : QMAX;
                  remainder   <= '0;
                  div_by_zero <= 1'b1;
                  overflow    <= 1'b0;
               end else if (ovf_case) begin
`ifdef DIV_SAT_EN
                  quotient    <= QMAX;
`else
                  quotient    <= QMIN;
`endif
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b1;
               end else begin
                  quotient    <= (dvd_neg ^ dvs_neg) ? -dq : dq;
                  remainder   <= dvd_neg ? -prem[W-1:0] : prem[W-1:0];
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
               state <= DONE;
            end
            DONE: begin
               // First DONE cycle raises out_valid; the handshake is only honoured once it is visible.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_div_signed16by8.sv
// Scoreboard bench for seq_div_signed16by8: directed corner cases plus random operands against
// an integer-division reference model; a negedge monitor checks results, latency, hold and in_ready.
module tb_seq_div_signed16by8;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   bit   busy     = 0;
   bit   hold_rdy = 0;

   seq_div_signed16by8 #(.W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
   endtask

   // Reference: plain truncating integer division plus the two exception rules.
   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
      exp_t e;
      int ai, bi, q, r;
      ai = int'($signed(a));
      bi = int'($signed(b));
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      e.lat = 18;
      if (bi == 0) begin
         e.dbz = 1'b1;
         e.lat = 2;
         q = (ai >= 0) ? 32767 : -32768;
         r = 0;
      end else if (ai == -32768 && bi == -1) begin
         e.ovf = 1'b1;
`ifdef DIV_SAT_EN
         q = 32767;
`else
         q = -32768;
`endif
         r = 0;
      end else begin
         q = ai / bi;
         r = ai % bi;
      end
      e.q = q[15:0];
      e.r = r[7:0];
      return e;
   endfunction

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard when out_valid rises, then holds the same expectation while stalled.
   initial begin
      exp_t cur;
      bit   pv;
      pv = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0;
            pv   = 0;
         end else begin
            check("in_ready", in_ready, !busy);
            if (out_valid) begin
               if (!pv) begin
                  if (exp_q.size() == 0) begin
                     fail_now("unexpected_result");
                     cur = '{q: quotient, r: remainder, dbz: div_by_zero, ovf: overflow, lat: 0};
                  end else begin
                     cur = exp_q.pop_front();
                     check("latency", cyc - acc_cyc, cur.lat);
                  end
               end
               check("quotient", quotient, cur.q);
               check("remainder", remainder, cur.r);
               check("div_by_zero", div_by_zero, cur.dbz);
               check("overflow", overflow, cur.ovf);
            end
            if (in_valid && in_ready) begin
               busy    = 1;
               acc_cyc = cyc + 1;
            end
            if (out_valid && out_ready) busy = 0;
            pv = out_valid && !out_ready;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input logic [15:0] a, input logic [7:0] b, input bit keep);
      int t;
      t = 0;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) fail_now("accept_timeout");
      else exp_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      if (!keep) begin
         in_valid = 1'b0;
         dividend = 16'($urandom);
         divisor  = 8'($urandom);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      logic [7:0]  b;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_flags", {div_by_zero, overflow}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      send(16'd1000, 8'd7, 0);
      send(-16'sd1000, 8'd7, 0);
      send(16'd1000, -8'sd7, 0);
      send(-16'sd1000, -8'sd7, 0);
      send(16'h8000, 8'hFF, 0);
      send(16'h8000, 8'h01, 0);
      send(16'd123, 8'd0, 0);
      send(-16'sd5, 8'd0, 0);
      send(16'd0, 8'h80, 0);
      send(16'h7FFF, 8'h80, 0);

      // Back-to-back with in_valid held: second op must wait for IDLE.
      send(16'd300, 8'd3, 1);
      send(-16'sd7000, 8'd9, 0);
      wait_idle();

      // Stall in DONE: outputs, out_valid and in_ready must hold.
      hold_rdy = 1;
      @(posedge clk);
      #1;
      send(16'd123, 8'd0, 0);
      begin
         int t;
         t = 0;
         @(negedge clk);
         while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
         end
         if (!out_valid) fail_now("stall_wait");
      end
      repeat (5) begin
         @(negedge clk);
         check("stall_out_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
      end
      hold_rdy = 0;
      wait_idle();

      // Asynchronous reset in the middle of CALC discards the operation.
      @(posedge clk);
      #1;
      send(16'd1000, 8'd7, 0);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_quotient", quotient, 0);
      check("midrst_flags", {div_by_zero, overflow}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_in_ready", in_ready, 1);
      check("postrst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 2500; i++) begin
         case ($urandom_range(0, 15))
            0:       b = 8'h00;
            1:       b = 8'hFF;
            2:       b = 8'h01;
            3:       b = 8'h80;
            default: b = 8'($urandom);
         endcase
         a = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
         send(a, b, 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wait_idle();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
